// File: rtl/mpu_det_sequencer_if.sv
// Request/response bundle between the MPU instruction decoder and the
// determinant sequencer. The decoder drives start/size/matrix; the
// sequencer returns busy/done/error/result.
interface mpu_det_sequencer_if;
    logic         start;
    logic [7:0]   size;
    logic [199:0] matrix;
    logic         busy;
    logic         done;
    logic         error;
    logic [7:0]   result;

    modport master (
        output start, size, matrix,
        input  busy, done, error, result
    );

    modport slave (
        input  start, size, matrix,
        output busy, done, error, result
    );
endinterface : mpu_det_sequencer_if

// File: rtl/mpu_det_sequencer.sv
// Multi-cycle determinant sequencer for 1x1..5x5 signed 8-bit matrices.
// A single shared 3x3 cofactor unit is stepped by a two-state FSM:
//   N=1..3 : one step, N=4 : four first-row cofactors,
//   N=5    : twenty (row0, row1) double-expansion terms.
// All arithmetic wraps modulo 256.
module mpu_det_sequencer #(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    mpu_det_sequencer_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Architectural state
    state_t              r_state;
    logic [DATA_W-1:0]   r_m [MAX_N*MAX_N];
    logic [7:0]          r_size;
    logic [DATA_W-1:0]   r_acc;
    logic [2:0]          r_j;
    logic [1:0]          r_k;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [DATA_W-1:0]   r_result;

    // Next-state values
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic [2:0]          w_j_nxt;
    logic [1:0]          w_k_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_error_nxt;
    logic [DATA_W-1:0]   w_result_nxt;
    logic                w_latch;

    // Step datapath
    logic                w_size_ok;
    logic [2:0]          w_n;
    logic                w_last;
    logic [2:0]          w_rb;
    logic [2:0]          w_ck;
    logic [2:0]          w_ca;
    logic [2:0]          w_cb;
    logic [2:0]          w_c0, w_c1, w_c2;
    logic [DATA_W-1:0]   w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_i;
    logic [DATA_W-1:0]   w_d3;
    logic [DATA_W-1:0]   w_fac;
    logic                w_neg;
    logic [DATA_W-1:0]   w_prod;
    logic [DATA_W-1:0]   w_term;
    logic [DATA_W-1:0]   w_acc_step;

    // Element (row, col) of the latched row-major matrix.
    function automatic logic [DATA_W-1:0] elem(input logic [2:0] row, input logic [2:0] col);
        logic [4:0] idx;
        idx = 5'(row) * 5'd5 + 5'(col);
        return r_m[idx];
    endfunction

    // i-th ascending column index after removing columns a and b (a < b).
    function automatic logic [2:0] skip_cols(input logic [2:0] i, input logic [2:0] a,
                                             input logic [2:0] b);
        logic [2:0] x;
        x = i;
        if (x >= a) x = x + 3'd1;
        if (x >= b) x = x + 3'd1;
        return x;
    endfunction

    // Dimension is an 8-bit signed value; negatives are large unsigned and fail here.
    assign w_size_ok = (r_size >= 8'd1) && (r_size <= 8'd5);
    assign w_n       = r_size[2:0];

    // Select the 3x3 minor, its multiplier and sign for the current (j, k) step.
    always_comb begin : step_select
        // NOTE: every combinational output is given a default first so no path
        // through the case statements can leave it unassigned and infer a latch.
        w_rb   = 3'd0;
        w_ca   = 3'd7;
        w_cb   = 3'd7;
        w_fac  = 8'd1;
        w_neg  = 1'b0;
        w_ck   = ({1'b0, r_k} >= r_j) ? ({1'b0, r_k} + 3'd1) : {1'b0, r_k};
        w_last = 1'b1;
        case (w_n)
            3'd4: begin
                w_rb   = 3'd1;
                w_ca   = r_j;
                w_fac  = elem(3'd0, r_j);
                w_neg  = r_j[0];
                w_last = (r_j == 3'd3);
            end
            3'd5: begin
                w_rb   = 3'd2;
                w_ca   = (r_j < w_ck) ? r_j : w_ck;
                w_cb   = (r_j < w_ck) ? w_ck : r_j;
                w_fac  = elem(3'd0, r_j) * elem(3'd1, w_ck);
                w_neg  = r_j[0] ^ r_k[0];
                w_last = (r_j == 3'd4) && (r_k == 2'd3);
            end
            default: ;
        endcase
    end

    // Shared 3x3 cofactor unit and accumulator update.
    always_comb begin : cofactor_unit
        w_c0 = skip_cols(3'd0, w_ca, w_cb);
        w_c1 = skip_cols(3'd1, w_ca, w_cb);
        w_c2 = skip_cols(3'd2, w_ca, w_cb);
        w_a  = elem(w_rb,        w_c0);
        w_b  = elem(w_rb,        w_c1);
        w_c  = elem(w_rb,        w_c2);
        w_d  = elem(w_rb + 3'd1, w_c0);
        w_e  = elem(w_rb + 3'd1, w_c1);
        w_f  = elem(w_rb + 3'd1, w_c2);
        w_g  = elem(w_rb + 3'd2, w_c0);
        w_h  = elem(w_rb + 3'd2, w_c1);
        w_i  = elem(w_rb + 3'd2, w_c2);
        w_d3 = w_a * (w_e * w_i - w_f * w_h)
             - w_b * (w_d * w_i - w_f * w_g)
             + w_c * (w_d * w_h - w_e * w_g);
        w_prod = w_fac * w_d3;
        case (w_n)
            3'd1:    w_term = elem(3'd0, 3'd0);
            3'd2:    w_term = elem(3'd0, 3'd0) * elem(3'd1, 3'd1)
                            - elem(3'd0, 3'd1) * elem(3'd1, 3'd0);
            default: w_term = w_neg ? (8'd0 - w_prod) : w_prod;
        endcase
        w_acc_step = r_acc + w_term;
    end

    // FSM next-state and output decisions.
    always_comb begin : fsm_next
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_j_nxt      = r_j;
        w_k_nxt      = r_k;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_error_nxt  = r_error;
        w_result_nxt = r_result;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_latch     = 1'b1;
                    w_acc_nxt   = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_size_ok) begin
                    w_result_nxt = '0;
                    w_error_nxt  = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else if (w_last) begin
                    w_acc_nxt    = w_acc_step;
                    w_result_nxt = w_acc_step;
                    w_error_nxt  = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_acc_nxt = w_acc_step;
                    if (w_n == 3'd5) begin
                        if (r_k == 2'd3) begin
                            w_k_nxt = 2'd0;
                            w_j_nxt = r_j + 3'd1;
                        end else begin
                            w_k_nxt = r_k + 2'd1;
                        end
                    end else begin
                        w_j_nxt = r_j + 3'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control/result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin : state_regs
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_error  <= w_error_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Operand capture on job acceptance.
    always_ff @(posedge clock) begin : operand_latch
        // NOTE: the operand store has no reset; it is always written on accept
        // before any step reads it, so resetting it would only add logic.
        if (w_latch) begin
            r_size <= bus.size;
            for (int i = 0; i < MAX_N * MAX_N; i++) begin
                r_m[i] <= bus.matrix[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.error  = r_error;
    assign bus.result = r_result;

endmodule : mpu_det_sequencer
